// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: load handshake, double-dabble / hex conversion,
// double-buffered digit codes and a prescaled one-hot digit scan.
module seg_scan_display #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    input  logic              hex_mode,
    input  logic              signed_en,
    input  logic              blank_en,
    output logic              busy,
    output logic              overflow,
    output logic [7:0]        seg_data_pin,
    output logic [DIGITS-1:0] seg_cs_pin
);

    localparam int unsigned BCD_D = DATA_W * 3 / 10 + 1;
    localparam int unsigned HEX_D = (DATA_W + 3) / 4;
    localparam int unsigned NUM_D = (BCD_D > HEX_D) ? BCD_D : HEX_D;
    localparam int unsigned NUM_W = NUM_D * 4;
    localparam int unsigned EXT_D = (NUM_D > DIGITS) ? NUM_D : DIGITS;
    localparam int unsigned EXT_W = EXT_D * 4;
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Display buffer codes: 0..15 digit value, plus two special glyphs
    localparam logic [4:0] CODE_MINUS = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CONV   = 2'd1,
        S_COMMIT = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic                         accept_c, conv_c, commit_c;

    logic [DATA_W-1:0]            mag_q, mag_in;
    logic                         neg_in;
    logic                         hex_q, neg_q, blank_q;
    logic [NUM_D-1:0][3:0]        bcd_q, bcd_d, bcd_adj;
    logic [NUM_W-1:0]             bcd_flat;
    logic [CNT_W-1:0]             bitcnt_q;
    logic                         busy_q;
    logic                         overflow_q;

    logic [DIGITS-1:0][4:0]       disp_q, disp_c;
    logic                         ovf_c;
    logic [EXT_D-1:0][3:0]        ext_c;

    logic [PRE_W-1:0]             pre_q;
    logic [IDX_W-1:0]             idx_q;
    logic [7:0]                   seg_q;
    logic [DIGITS-1:0]            cs_q;

    // Digit code to active-low pin pattern {dp,cg,cf,ce,cd,cc,cb,ca}
    function automatic logic [7:0] glyph(input logic [4:0] code);
        logic [7:0] t;  // written {ca..cg,dp}
        logic [7:0] g;
        case (code)
            5'd0:    t = 8'b00000011;
            5'd1:    t = 8'b10011111;
            5'd2:    t = 8'b00100101;
            5'd3:    t = 8'b00001101;
            5'd4:    t = 8'b10011001;
            5'd5:    t = 8'b01001001;
            5'd6:    t = 8'b01000001;
            5'd7:    t = 8'b00011111;
            5'd8:    t = 8'b00000001;
            5'd9:    t = 8'b00011001;
            5'd10:   t = 8'b00010001;
            5'd11:   t = 8'b11000001;
            5'd12:   t = 8'b01100011;
            5'd13:   t = 8'b10000101;
            5'd14:   t = 8'b01100001;
            5'd15:   t = 8'b01110001;
            5'd16:   t = 8'b11111101;
            default: t = 8'b11111111;
        endcase
        for (int b = 0; b < 8; b++) begin
            g[b] = t[7-b];
        end
        return g;
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (load) state_d = S_CONV;
            S_CONV:   if (hex_q || (bitcnt_q == CNT_W'(DATA_W - 1))) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM output strobes
    always_comb begin
        accept_c = 1'b0;
        conv_c   = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            S_IDLE:   accept_c = load;
            S_CONV:   conv_c   = 1'b1;
            S_COMMIT: commit_c = 1'b1;
            default:  ;
        endcase
    end

    // Operand sign handling at load time
    always_comb begin
        neg_in = signed_en & ~hex_mode & data_in[DATA_W-1];
        mag_in = neg_in ? (~data_in + DATA_W'(1)) : data_in;
    end

    // One conversion step: hex copies nibbles, decimal does add-3 then shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < int'(NUM_D); k++) begin
            if (bcd_q[k] >= 4'd5) begin
                bcd_adj[k] = bcd_q[k] + 4'd3;
            end
        end
        bcd_flat = bcd_adj;
        if (hex_q) begin
            bcd_d = NUM_W'(mag_q);
        end else begin
            bcd_d = {bcd_flat[NUM_W-2:0], mag_q[DATA_W-1]};
        end
    end

    // Conversion datapath and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q    <= '0;
            hex_q    <= 1'b0;
            neg_q    <= 1'b0;
            blank_q  <= 1'b0;
            bcd_q    <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= (state_d != S_IDLE);
            if (accept_c) begin
                mag_q    <= mag_in;
                hex_q    <= hex_mode;
                neg_q    <= neg_in;
                blank_q  <= blank_en;
                bcd_q    <= '0;
                bitcnt_q <= '0;
            end else if (conv_c) begin
                bcd_q    <= bcd_d;
                mag_q    <= {mag_q[DATA_W-2:0], 1'b0};
                bitcnt_q <= bitcnt_q + CNT_W'(1);
            end
        end
    end

    // Overflow, sign and leading-zero blanking applied to the converted digits
    always_comb begin
        logic       zero_above;
        logic [4:0] code;
        int         lim;
        ext_c      = EXT_W'(NUM_W'(bcd_q));
        lim        = neg_q ? int'(DIGITS) - 1 : int'(DIGITS);
        ovf_c      = 1'b0;
        zero_above = 1'b1;
        code       = CODE_BLANK;
        disp_c     = '0;
        for (int k = 0; k < int'(EXT_D); k++) begin
            if ((k >= lim) && (ext_c[k] != 4'd0)) begin
                ovf_c = 1'b1;
            end
        end
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            zero_above = zero_above & (ext_c[i] == 4'd0);
            if (ovf_c) begin
                code = CODE_MINUS;
            end else if (neg_q && (i == int'(DIGITS) - 1)) begin
                code = CODE_MINUS;
            end else if (blank_q && (i != 0) && zero_above) begin
                code = CODE_BLANK;
            end else begin
                code = {1'b0, ext_c[i]};
            end
            disp_c[i] = code;
        end
    end

    // Display buffer and overflow flag, written once per conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q     <= {DIGITS{CODE_BLANK}};
            overflow_q <= 1'b0;
        end else if (commit_c) begin
            disp_q     <= disp_c;
            overflow_q <= ovf_c;
        end
    end

    // Digit scan: select and segment pattern change together at terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= 8'hFF;
            cs_q  <= '1;
        end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            cs_q  <= ~(DIGITS'(1) << idx_q);
            seg_q <= glyph(disp_q[idx_q]);
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

    assign busy         = busy_q;
    assign overflow     = overflow_q;
    assign seg_data_pin = seg_q;
    assign seg_cs_pin   = cs_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomized self-checking bench for seg_scan_display against an arithmetic display model.
module tb_seg_scan_display;

    localparam int DW = 32;
    localparam int ND = 8;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [DW-1:0] data_in;
    logic          hex_mode;
    logic          signed_en;
    logic          blank_en;
    logic          busy;
    logic          overflow;
    logic [7:0]    seg_data_pin;
    logic [ND-1:0] seg_cs_pin;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_seg [ND];
    logic       exp_ovf;

    // Reference glyph table written {ca..cg,dp}; index 16 = minus, 17 = blank
    logic [7:0] gly_tab [18] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00011001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001,
        8'b11111101, 8'b11111111
    };

    seg_scan_display #(
        .DATA_W  (DW),
        .DIGITS  (ND),
        .SCAN_DIV(SD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .data_in     (data_in),
        .hex_mode    (hex_mode),
        .signed_en   (signed_en),
        .blank_en    (blank_en),
        .busy        (busy),
        .overflow    (overflow),
        .seg_data_pin(seg_data_pin),
        .seg_cs_pin  (seg_cs_pin)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pin_of(input int code);
        logic [7:0] s;
        logic [7:0] r;
        s = gly_tab[code];
        r = {<<{s}};
        return r;
    endfunction

    // Expected panel contents from plain arithmetic on the value
    task automatic model(input logic [DW-1:0] d, input logic h, input logic sg, input logic bl);
        longint unsigned m, base, p, w;
        logic            neg;
        int              code, lim;
        neg  = sg && !h && d[DW-1];
        m    = neg ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
        base = h ? 64'd16 : 64'd10;
        lim  = neg ? ND - 1 : ND;
        p    = 1;
        for (int i = 0; i < lim; i++) p = p * base;
        exp_ovf = (m >= p);
        for (int i = 0; i < ND; i++) begin
            w = 1;
            for (int j = 0; j < i; j++) w = w * base;
            if (exp_ovf)                      code = 16;
            else if (neg && i == ND - 1)      code = 16;
            else if (bl && i > 0 && m / w == 0) code = 17;
            else                              code = int'((m / w) % base);
            exp_seg[i] = pin_of(code);
        end
    endtask

    // Watch refreshes until every digit has been shown once, then compare
    task automatic collect(input string tag);
        logic [7:0]    shown [ND];
        logic [ND-1:0] seen;
        logic [ND-1:0] prev;
        int            n;
        seen = '0;
        prev = seg_cs_pin;
        n    = 0;
        for (int i = 0; i < ND; i++) shown[i] = 8'h00;
        while (seen != '1 && n < ND * SD * 3) begin
            @(negedge clk);
            n++;
            if (seg_cs_pin != prev) begin
                for (int j = 0; j < ND; j++) begin
                    if (seg_cs_pin[j] == 1'b0) begin
                        shown[j] = seg_data_pin;
                        seen[j]  = 1'b1;
                    end
                end
            end
            prev = seg_cs_pin;
        end
        check_eq({tag, "_all_refreshed"}, 64'(seen), 64'(8'hFF));
        for (int i = 0; i < ND; i++) begin
            check_eq($sformatf("%s_d%0d", tag, i), 64'(shown[i]), 64'(exp_seg[i]));
        end
    endtask

    // One conversion; poke_at >= 0 re-asserts load that many busy cycles in
    task automatic run(input logic [DW-1:0] d, input logic h, input logic sg, input logic bl,
                       input string tag, input int poke_at);
        int n;
        model(d, h, sg, bl);
        @(negedge clk);
        data_in   = d;
        hex_mode  = h;
        signed_en = sg;
        blank_en  = bl;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
        data_in   = $urandom;
        hex_mode  = 1'($urandom);
        signed_en = 1'($urandom);
        blank_en  = 1'($urandom);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            load = (n == poke_at);
            if (n == poke_at) data_in = $urandom;
            @(negedge clk);
        end
        load = 1'b0;
        check_eq({tag, "_busy_len"}, 64'(n), h ? 64'd2 : 64'(DW + 1));
        check_eq({tag, "_ovf"}, 64'(overflow), 64'(exp_ovf));
        collect(tag);
    endtask

    initial begin
        logic [DW-1:0] d;
        int            n, h, sel;
        logic [ND-1:0] exp_cs;
        logic [ND-1:0] cur;

        rst_n     = 1'b0;
        load      = 1'b0;
        data_in   = '0;
        hex_mode  = 1'b0;
        signed_en = 1'b0;
        blank_en  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);
        check_eq("rst_seg", 64'(seg_data_pin), 64'hFF);
        check_eq("rst_cs", 64'(seg_cs_pin), 64'hFF);
        rst_n = 1'b1;

        // Scan timing from reset: first digit after SD cycles, each held SD cycles
        n = 0;
        while (seg_cs_pin == '1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("scan_first_en", 64'(n), 64'(SD));
        for (int r = 0; r < 2 * ND; r++) begin
            exp_cs = ~(ND'(1) << (r % ND));
            check_eq($sformatf("scan_cs_%0d", r), 64'(seg_cs_pin), 64'(exp_cs));
            check_eq($sformatf("scan_seg_%0d", r), 64'(seg_data_pin), 64'(pin_of(17)));
            cur = seg_cs_pin;
            h = 0;
            while (seg_cs_pin == cur && h < 20) begin
                @(negedge clk);
                h++;
            end
            check_eq($sformatf("scan_hold_%0d", r), 64'(h), 64'(SD));
        end

        // Directed cases
        run(32'd12345678, 1'b0, 1'b0, 1'b0, "dec_12345678", -1);
        run(32'hFFFFFF85, 1'b0, 1'b1, 1'b1, "neg_123_blank", -1);
        run(32'hDEADBEEF, 1'b1, 1'b1, 1'b0, "hex_deadbeef", -1);
        run(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "ovf_umax", -1);
        run(32'h80000000, 1'b0, 1'b1, 1'b0, "ovf_smin", -1);
        run(32'd0, 1'b0, 1'b0, 1'b1, "zero_blank", -1);
        run(32'd99999999, 1'b0, 1'b0, 1'b0, "dec_max_fit", -1);
        run(32'd100000000, 1'b0, 1'b0, 1'b0, "dec_first_ovf", -1);
        run(32'hFF676981, 1'b0, 1'b1, 1'b0, "neg_9999999", -1);
        run(32'hFF676980, 1'b0, 1'b1, 1'b0, "neg_10000000", -1);
        run(32'd42, 1'b0, 1'b0, 1'b1, "load_in_busy", 5);
        run(32'h0000ABC0, 1'b1, 1'b0, 1'b1, "hex_load_in_busy", 1);

        // Reset in the middle of a decimal conversion discards it
        @(negedge clk);
        data_in   = 32'd777;
        hex_mode  = 1'b0;
        signed_en = 1'b0;
        blank_en  = 1'b0;
        load      = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_cs", 64'(seg_cs_pin), 64'hFF);
        check_eq("midrst_seg", 64'(seg_data_pin), 64'hFF);
        check_eq("midrst_busy", 64'(busy), 64'd0);
        check_eq("midrst_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < ND; i++) exp_seg[i] = pin_of(17);
        collect("midrst_blank");
        @(negedge clk);
        check_eq("midrst_idle", 64'(busy), 64'd0);

        // Randomized values and modes
        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 4));
            case (sel)
                0:       d = $urandom;
                1:       d = 32'($urandom_range(0, 999));
                2:       d = 32'($urandom_range(0, 99999999));
                3:       d = -32'($urandom_range(1, 9999999));
                default: d = 32'($urandom_range(0, 32'h00FFFFFF));
            endcase
            run(d, 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rnd%0d", t), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
